// File: rtl/proc_pkg.sv
// Shared processor-slice definitions: default bus widths and the read-return
// owner encoding used by the memory arbiter.
package proc_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the memory arbiter: counts consecutive CPU grants
// while DMA waits, saturating at STARVE_MAX; hold takes priority over clear.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_at_max
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_hold) begin
      r_cnt <= r_cnt;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_max = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU control unit and a DMA/loader port.
// Optional `ARB_LOCK_EN adds cpu_lock, which blocks DMA grants and freezes starvation.
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
`ifdef ARB_LOCK_EN
  input  logic              cpu_lock,
`endif
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   w_lock;
  logic   w_at_max;
  logic   w_gnt_cpu;
  logic   w_gnt_dma;
  logic   w_rv;
  logic   r_rd_pend;
  owner_e r_rd_owner;

`ifdef ARB_LOCK_EN
  assign w_lock = cpu_lock;
`else
  assign w_lock = 1'b0;
`endif

  // CPU wins ties until the DMA port has waited STARVE_MAX grants.
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_dma = 1'b0;
    if (!rst) begin
      if (dma_req && !w_lock && (!cpu_req || w_at_max)) begin
        w_gnt_dma = 1'b1;
      end else if (cpu_req) begin
        w_gnt_cpu = 1'b1;
      end
    end
  end

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_gnt_cpu & dma_req),
    .i_clr   (w_gnt_dma | ~dma_req),
    .i_hold  (w_lock),
    .o_at_max(w_at_max)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (w_gnt_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_read  = ~dma_we;
      mem_write = dma_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_CPU;
    end else begin
      r_rd_pend <= (w_gnt_cpu & ~cpu_we) | (w_gnt_dma & ~dma_we);
      if (w_gnt_dma) begin
        r_rd_owner <= OWN_DMA;
      end else if (w_gnt_cpu) begin
        r_rd_owner <= OWN_CPU;
      end
    end
  end

  // Gating with rst drops a read still in flight when reset arrives.
  assign w_rv       = r_rd_pend & ~rst;
  assign cpu_rvalid = w_rv & (r_rd_owner == OWN_CPU);
  assign dma_rvalid = w_rv & (r_rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

  assign cpu_gnt = w_gnt_cpu;
  assign dma_gnt = w_gnt_dma;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, arbitration model and
// a read-return scoreboard; the lock scenario runs only with `ARB_LOCK_EN.
module tb_mem_arbiter;
  import proc_pkg::*;

  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dma_req, dma_we;
  logic [7:0] dma_addr, dma_wdata;
  logic       dma_gnt, dma_rvalid;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       own;
    logic [7:0] data;
  } rd_t;
  rd_t         sbq[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  mem     [256];
  int unsigned m_starve = 0;

  mem_arbiter #(
    .ADDR_W(8),
    .DATA_W(8),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
`ifdef ARB_LOCK_EN
    .cpu_lock  (cpu_lock),
`endif
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Write-first single-port memory; read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] = mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  // Expected {dma_gnt, cpu_gnt} for the current inputs and model state.
  function automatic logic [1:0] exp_gnt();
    if (rst) return 2'b00;
    case ({cpu_req, dma_req})
      2'b10:   return 2'b01;
      2'b01:   return cpu_lock ? 2'b00 : 2'b10;
      2'b11:   return (!cpu_lock && m_starve >= STARVE_MAX) ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic commit(input logic [1:0] g);
    rd_t e;
    if (rst) begin
      m_starve = 0;
      return;
    end
    if (!cpu_lock) begin
      if (g[1] || !dma_req) m_starve = 0;
      else if (g[0] && m_starve < STARVE_MAX) m_starve++;
    end
    if (g[0]) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else begin e.own = OWN_CPU; e.data = ref_mem[cpu_addr]; sbq.push_back(e); end
    end
    if (g[1]) begin
      if (dma_we) ref_mem[dma_addr] = dma_wdata;
      else begin e.own = OWN_DMA; e.data = ref_mem[dma_addr]; sbq.push_back(e); end
    end
  endtask

  task automatic sb_expect(output logic [1:0] ev, output logic [7:0] ec, output logic [7:0] ed);
    rd_t e;
    ev = '0; ec = '0; ed = '0;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (!rst) begin
        if (e.own == OWN_DMA) begin ev = 2'b10; ed = e.data; end
        else begin ev = 2'b01; ec = e.data; end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] ev;
    logic [7:0] ec, ed;
    rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b1;
    cpu_addr = 8'h10; dma_addr = 8'h11; cpu_wdata = 8'h77; dma_wdata = 8'h88;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sb_expect(ev, ec, ed);
      n_checks++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write} !== 6'b0 ||
          mem_addr !== 8'h00 || mem_wdata !== 8'h00 || cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: gnt=%b%b rv=%b%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                 i, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write, mem_addr, mem_wdata);
      end
      commit(2'b00);
      next_cycle();
    end
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_cpu_read();
    logic [1:0] g, ev;
    logic [7:0] ec, ed;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; dma_req = 1'b0;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL cpu_read_cmd: gnt=%b%b rd=%b wr=%b addr=%h, want gnt=10 rd=1 wr=0 addr=10",
               cpu_gnt, dma_gnt, mem_read, mem_write, mem_addr);
    end
    commit(g);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || dma_rvalid !== 1'b0 || dma_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL cpu_read_data: cpu_rv=%b cpu_rd=%h dma_rv=%b dma_rd=%h, want 1 a5 0 00",
               cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata);
    end
    n_checks++;
    if ({dma_rvalid, cpu_rvalid} !== ev || cpu_rdata !== ec) begin
      n_fail++;
      $display("FAIL cpu_read_sb: rv=%b rd=%h, want rv=%b rd=%h", {dma_rvalid, cpu_rvalid}, cpu_rdata, ev, ec);
    end
    commit(g);
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [1:0] g, ev, want;
    logic [7:0] ec, ed, ea;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h31;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin cpu_req = 1'b0; dma_req = 1'b0; end
      @(negedge clk);
      g = exp_gnt(); sb_expect(ev, ec, ed);
      want = (i == 15) ? 2'b00 : ((i % 5) == 4) ? 2'b10 : 2'b01;
      ea = want[0] ? 8'h30 : want[1] ? 8'h31 : 8'h00;
      n_checks++;
      if ({dma_gnt, cpu_gnt} !== want || mem_addr !== ea || mem_read !== (want != 2'b00)) begin
        n_fail++;
        $display("FAIL starve_gnt cyc %0d: gnt=%b addr=%h rd=%b, want gnt=%b addr=%h",
                 i, {dma_gnt, cpu_gnt}, mem_addr, mem_read, want, ea);
      end
      n_checks++;
      if ({dma_rvalid, cpu_rvalid} !== ev || cpu_rdata !== ec || dma_rdata !== ed) begin
        n_fail++;
        $display("FAIL starve_rdata cyc %0d: rv=%b cpu=%h dma=%h, want rv=%b cpu=%h dma=%h",
                 i, {dma_rvalid, cpu_rvalid}, cpu_rdata, dma_rdata, ev, ec, ed);
      end
      commit(g);
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    logic [1:0] g, ev;
    logic [7:0] ec, ed;
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h3C;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL wr_cmd: gnt=%b%b wr=%b rd=%b addr=%h wdata=%h, want gnt=01 wr=1 rd=0 addr=20 wdata=3c",
               cpu_gnt, dma_gnt, mem_write, mem_read, mem_addr, mem_wdata);
    end
    commit(g);
    next_cycle();
    dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h20 || dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_wr_cmd: gnt=%b rd=%b wr=%b addr=%h dma_rv=%b, want 1 1 0 20 0",
               cpu_gnt, mem_read, mem_write, mem_addr, dma_rvalid);
    end
    commit(g);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h3C || cpu_rdata !== ec) begin
      n_fail++;
      $display("FAIL rd_after_wr_data: rv=%b rd=%h, want rv=1 rd=3c", cpu_rvalid, cpu_rdata);
    end
    commit(g);
    next_cycle();
  endtask

  task automatic test_alternating();
    logic [1:0] g, ev;
    logic [7:0] ec, ed;
    cpu_we = 1'b0; dma_we = 1'b0; cpu_addr = 8'h01; dma_addr = 8'h02;
    for (int i = 0; i < 9; i++) begin
      cpu_req = (i < 8) && (i % 2 == 0);
      dma_req = (i < 8) && (i % 2 == 1);
      @(negedge clk);
      g = exp_gnt(); sb_expect(ev, ec, ed);
      n_checks++;
      if ({dma_gnt, cpu_gnt} !== g) begin
        n_fail++;
        $display("FAIL alt_gnt cyc %0d: gnt=%b, want %b", i, {dma_gnt, cpu_gnt}, g);
      end
      n_checks++;
      if ({dma_rvalid, cpu_rvalid} !== ev || cpu_rdata !== ec || dma_rdata !== ed) begin
        n_fail++;
        $display("FAIL alt_rdata cyc %0d: rv=%b cpu=%h dma=%h, want rv=%b cpu=%h dma=%h",
                 i, {dma_rvalid, cpu_rvalid}, cpu_rdata, dma_rdata, ev, ec, ed);
      end
      commit(g);
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, ev;
    logic [7:0] ec, ed;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; dma_req = 1'b0;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_gnt: cpu_gnt=%b, want 1", cpu_gnt);
    end
    commit(g);
    next_cycle();
    rst = 1'b1; cpu_addr = 8'h11; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h12;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write} !== 6'b0 ||
        mem_addr !== 8'h00 || cpu_rdata !== 8'h00 || {dma_rvalid, cpu_rvalid} !== ev) begin
      n_fail++;
      $display("FAIL rstmid_outputs: gnt=%b%b rv=%b%b rd=%b wr=%b addr=%h cpu_rd=%h, want all 0",
               cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_read, mem_write, mem_addr, cpu_rdata);
    end
    commit(g);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    g = exp_gnt(); sb_expect(ev, ec, ed);
    n_checks++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_addr !== 8'h11 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_first_gnt: gnt=%b%b addr=%h rv=%b%b, want gnt=10 addr=11 rv=00",
               cpu_gnt, dma_gnt, mem_addr, cpu_rvalid, dma_rvalid);
    end
    commit(g);
    next_cycle();
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      g = exp_gnt(); sb_expect(ev, ec, ed);
      n_checks++;
      if ({dma_gnt, cpu_gnt} !== g || {dma_rvalid, cpu_rvalid} !== ev || cpu_rdata !== ec || dma_rdata !== ed) begin
        n_fail++;
        $display("FAIL rstmid_drain cyc %0d: gnt=%b rv=%b cpu=%h dma=%h, want gnt=%b rv=%b cpu=%h dma=%h",
                 i, {dma_gnt, cpu_gnt}, {dma_rvalid, cpu_rvalid}, cpu_rdata, dma_rdata, g, ev, ec, ed);
      end
      commit(g);
      next_cycle();
      dma_req = 1'b0;
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] g, ev;
    logic [7:0] ec, ed;
    int n_cpu, n_dma;
    n_cpu = 0; n_dma = 0;
    cpu_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h41;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) cpu_lock = 1'b0;
      if (i == 15) begin cpu_req = 1'b0; dma_req = 1'b0; end
      @(negedge clk);
      g = exp_gnt(); sb_expect(ev, ec, ed);
      if (i < 10) begin
        n_cpu += int'(cpu_gnt);
        n_dma += int'(dma_gnt);
      end
      n_checks++;
      if ({dma_gnt, cpu_gnt} !== g || (i == 14 && dma_gnt !== 1'b1)) begin
        n_fail++;
        $display("FAIL lock_gnt cyc %0d: gnt=%b, want %b", i, {dma_gnt, cpu_gnt}, g);
      end
      n_checks++;
      if ({dma_rvalid, cpu_rvalid} !== ev || cpu_rdata !== ec || dma_rdata !== ed) begin
        n_fail++;
        $display("FAIL lock_rdata cyc %0d: rv=%b cpu=%h dma=%h, want rv=%b cpu=%h dma=%h",
                 i, {dma_rvalid, cpu_rvalid}, cpu_rdata, dma_rdata, ev, ec, ed);
      end
      commit(g);
      next_cycle();
    end
    n_checks++;
    if (n_cpu != 10 || n_dma != 0) begin
      n_fail++;
      $display("FAIL lock_counts: cpu=%0d dma=%0d, want cpu=10 dma=0", n_cpu, n_dma);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    cpu_lock = 1'b0;
    test_reset();
    test_cpu_read();
    test_starvation();
    test_write_read();
    test_alternating();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
